cs_meas_streamer: RTL and testbench
===================================

# cs_meas_streamer

Downstream stage of the compressed-sensing encoder. When the encoder signals frame completion, this block copies the M signed measurement accumulators out of the encoder's read port into a local buffer. It scales and saturates each one to OUT_W bits. It then streams one frame (header word followed by M measurements) on a valid/ready interface toward the link/packetiser. The local buffer frees the encoder to start accumulating the next 2048-sample window during streaming.

## Interface
- M, 512, measurements per frame (power of two, ≥4)
- IN_W, 24, encoder accumulator width (signed)
- OUT_W, 16, output word width (signed)
- SHIFT, 6, arithmetic right shift applied before saturation
- AW, clog2(M) = 9, buffer/read address width
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high; clock clk
- encoder_done  in  1  one-cycle pulse: encoder measurements valid and stable for ≥ M+2 cycles
- rd_addr  out  AW  measurement index into encoder
- rd_data  in  IN_W  signed measurement at rd_addr, valid one cycle after rd_addr
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  OUT_W  header or scaled measurement
- m_first  out  1  high on header beat
- m_last  out  1  high on measurement M−1 beat
- busy  out  1  high in LOAD or SEND
- overrun  out  1  sticky: encoder_done arrived while busy
- sat_seen  out  1  sticky per frame: some measurement in the current frame saturated
- frame_cnt  out  OUT_W  frames fully sent, wraps

## Operation
- States: IDLE, LOAD, SEND.
- IDLE: rd_addr=0, m_valid=0.
  - encoder_done=1 → LOAD; clear sat_seen.
- LOAD: issue rd_addr 0..M−1 on consecutive cycles.
  - Word returned for address k (one cycle later) is scaled and written to buffer[k].
  - After buffer[M−1] is written → SEND. LOAD lasts exactly M+1 cycles.
- Scaling:
  - s = rd_data >>> SHIFT (arithmetic, floor toward −∞).
  - If s > 2^(OUT_W−1)−1 → 2^(OUT_W−1)−1. If s < −2^(OUT_W−1) → −2^(OUT_W−1).
  - Any clamp sets sat_seen.
- SEND: M+1 beats.
  - Beat 0: m_data = frame_cnt, m_first=1.
  - Beats 1..M: m_data = buffer[0..M−1]; m_last=1 on buffer[M−1].
  - A beat transfers when m_valid & m_ready.
  - After the last transfer: frame_cnt += 1 (wraps at 2^OUT_W), → IDLE.
- encoder_done while busy: set overrun; the pulse is otherwise ignored, and the current frame continues unchanged.
- encoder_done in the same cycle the last SEND beat transfers: counts as busy → overrun; no new frame starts.

## Timing
- Reset values: state IDLE, rd_addr 0, m_valid 0, m_first 0, m_last 0, m_data 0, busy 0, overrun 0, sat_seen 0, frame_cnt 0. Buffer contents are not reset.
- Reset mid-LOAD or mid-SEND:
  - Return to IDLE next edge and drop m_valid.
  - Partial frame is discarded; frame_cnt is not incremented.
- encoder_done sampled at edge T:
  - busy=1 and rd_addr=0 from T+1.
  - rd_addr=M−1 at T+M.
  - First m_valid=1 (header) at T+M+2.
- m_data, m_first and m_last are registered outputs.
- Once m_valid=1 it stays high, with data/markers stable, until accepted.
- m_valid never depends combinationally on m_ready.
- With m_ready held high, beats go out back-to-back: M+1 consecutive cycles, no bubbles.
- busy deasserts the cycle after the final beat transfers.
- Minimum encoder_done-to-IDLE: 2M+2 cycles (1026 at defaults).

## Test plan
- Basic frame:
  - Stimulus: encoder model returns rd_data = k<<6 for address k; m_ready=1; one encoder_done pulse.
  - Response: header 0 with m_first; then values 0..511; m_last only on 511; first valid exactly M+2 cycles after the pulse; frame_cnt=1 afterwards.
- Scaling/saturation:
  - Stimulus: rd_data values 0x012345, 0x7FFFFF, −1, −100, −0x800000.
  - Response: outputs 1165, 32767, −1, −2, −32768; sat_seen=1.
  - Re-run with in-range data only: sat_seen=0 after the new encoder_done.
- Backpressure:
  - Stimulus: random m_ready (~40% duty).
  - Response: all 513 beats delivered in order, none dropped or duplicated; m_data/m_first/m_last stable while valid & !ready.
- Overrun:
  - Stimulus: second encoder_done during LOAD, and a third one coincident with the final beat transfer.
  - Response: overrun=1; exactly one frame emitted; state IDLE afterwards.
  - A subsequent pulse after IDLE emits header 1.
- Reset mid-SEND:
  - Stimulus: assert reset after 100 accepted beats.
  - Response: next edge m_valid=0, busy=0, frame_cnt=0, overrun=0.
  - A following encoder_done yields a full frame with header 0.
- Frame counter wrap:
  - Stimulus: force frame_cnt = 0xFFFF, send one frame.
  - Response: header 0xFFFF; frame_cnt=0x0000 afterwards.

Source files
------------

// File: rtl/cs_meas_streamer.sv
// rtl/cs_meas_streamer.sv - snapshot encoder measurements, scale/saturate, stream one framed burst
// Buffering frees the encoder for the next window while the previous frame drains downstream.
module cs_meas_streamer #(
  parameter int M     = 512,
  parameter int IN_W  = 24,
  parameter int OUT_W = 16,
  parameter int SHIFT = 6,
  parameter int AW    = $clog2(M)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             encoder_done,
  output logic [AW-1:0]    rd_addr,
  input  logic [IN_W-1:0]  rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_first,
  output logic             m_last,
  output logic             busy,
  output logic             overrun,
  output logic             sat_seen,
  output logic [OUT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND} state_t;

  localparam logic [AW:0] CNT_LAST = (AW+1)'(M);
  localparam logic [AW:0] CNT_PEN  = (AW+1)'(M - 1);
  localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_MIN = -SAT_MAX - IN_W'(1);

  state_t r_state, w_state_nxt;

  // LOAD: cycles spent loading; SEND: index of the beat currently presented
  logic [AW:0]       r_cnt;
  logic [AW-1:0]     r_rd_addr;
  logic              r_m_valid, r_m_first, r_m_last, r_overrun, r_sat_seen;
  logic [OUT_W-1:0]  r_m_data, r_frame_cnt;
  logic [OUT_W-1:0]  r_buf [M];

  logic              w_xfer;
  logic [AW-1:0]     w_wr_addr;
  logic signed [IN_W-1:0] w_shifted;
  logic [OUT_W-1:0]  w_scaled;
  logic              w_clamp;

  assign w_xfer    = r_m_valid & m_ready;
  assign w_wr_addr = r_cnt[AW-1:0] - AW'(1);
  assign w_shifted = $signed(rd_data) >>> SHIFT;

  always_comb begin
    w_clamp  = 1'b0;
    w_scaled = w_shifted[OUT_W-1:0];
    if (w_shifted > SAT_MAX) begin
      w_clamp  = 1'b1;
      w_scaled = SAT_MAX[OUT_W-1:0];
    end else if (w_shifted < SAT_MIN) begin
      w_clamp  = 1'b1;
      w_scaled = SAT_MIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (encoder_done)                     w_state_nxt = ST_LOAD;
      ST_LOAD: if (r_cnt == CNT_LAST)                w_state_nxt = ST_SEND;
      ST_SEND: if (w_xfer && (r_cnt == CNT_LAST))    w_state_nxt = ST_IDLE;
      default:                                       w_state_nxt = ST_IDLE;
    endcase
  end

  // Word for address k arrives while r_cnt == k+1, so the write index lags by one.
  always_ff @(posedge clk) begin
    if ((r_state == ST_LOAD) && (r_cnt != '0)) r_buf[w_wr_addr] <= w_scaled;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_rd_addr   <= '0;
      r_m_valid   <= 1'b0;
      r_m_first   <= 1'b0;
      r_m_last    <= 1'b0;
      r_m_data    <= '0;
      r_overrun   <= 1'b0;
      r_sat_seen  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (encoder_done && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_cnt     <= '0;
          r_rd_addr <= '0;
          if (encoder_done) r_sat_seen <= 1'b0;
        end
        ST_LOAD: begin
          r_cnt <= r_cnt + (AW+1)'(1);
          if (r_cnt < CNT_PEN) r_rd_addr <= r_rd_addr + AW'(1);
          if ((r_cnt != '0) && w_clamp) r_sat_seen <= 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_rd_addr <= '0;
            r_m_valid <= 1'b1;
            r_m_first <= 1'b1;
            r_m_last  <= 1'b0;
            r_m_data  <= r_frame_cnt;
          end
        end
        ST_SEND: begin
          if (w_xfer) begin
            if (r_cnt == CNT_LAST) begin
              r_m_valid   <= 1'b0;
              r_m_last    <= 1'b0;
              r_frame_cnt <= r_frame_cnt + OUT_W'(1);
            end else begin
              r_cnt     <= r_cnt + (AW+1)'(1);
              r_m_data  <= r_buf[r_cnt[AW-1:0]];
              r_m_first <= 1'b0;
              r_m_last  <= (r_cnt == CNT_PEN);
            end
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign rd_addr   = r_rd_addr;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_first   = r_m_first;
  assign m_last    = r_m_last;
  assign busy      = (r_state != ST_IDLE);
  assign overrun   = r_overrun;
  assign sat_seen  = r_sat_seen;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_cs_meas_streamer.sv
// tb/tb_cs_meas_streamer.sv - directed-vector bench for cs_meas_streamer
module tb_cs_meas_streamer;
  localparam int M     = 512;
  localparam int IN_W  = 24;
  localparam int OUT_W = 16;
  localparam int SHIFT = 6;
  localparam int AW    = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic encoder_done = 1'b0;
  logic m_ready = 1'b0;
  logic rand_rdy = 1'b0;
  logic [AW-1:0]    rd_addr;
  logic [IN_W-1:0]  rd_data = '0;
  logic             m_valid, m_first, m_last, busy, overrun, sat_seen;
  logic [OUT_W-1:0] m_data, frame_cnt;

  logic [IN_W-1:0]  enc_mem [M];
  logic [OUT_W-1:0] exp_mem [M];
  logic [OUT_W-1:0] q_data [$];
  logic             q_first [$];
  logic             q_last [$];
  int n_checks = 0;
  int n_errors = 0;
  logic stall_prev = 1'b0;
  logic [OUT_W+1:0] hold_word = '0;

  cs_meas_streamer #(.M(M), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .AW(AW)) dut (
    .clk(clk), .reset(reset), .encoder_done(encoder_done),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_first(m_first), .m_last(m_last), .busy(busy),
    .overrun(overrun), .sat_seen(sat_seen), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Encoder read port: registered, data one cycle after address
  always @(posedge clk) rd_data <= enc_mem[rd_addr];

  always @(posedge clk) begin
    #1;
    m_ready = rand_rdy ? ($urandom_range(0, 99) < 40) : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // Beat capture plus hold-while-stalled checks
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(m_valid), 32'(1));
        check("hold_beat", 32'({m_first, m_last, m_data}), 32'(hold_word));
      end
      if (m_valid && m_ready) begin
        q_data.push_back(m_data);
        q_first.push_back(m_first);
        q_last.push_back(m_last);
      end
      stall_prev = m_valid && !m_ready;
      hold_word  = {m_first, m_last, m_data};
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_done();
    @(posedge clk);
    #1 encoder_done = 1'b1;
    @(posedge clk);
    #1 encoder_done = 1'b0;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_first.delete();
    q_last.delete();
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < M; k++) begin
      enc_mem[k] = IN_W'(k) << 6;
      exp_mem[k] = OUT_W'(k);
    end
  endtask

  task automatic check_frame(input logic [OUT_W-1:0] hdr);
    int e0;
    logic [OUT_W-1:0] want;
    check("beat_count", 32'(q_data.size()), 32'(M + 1));
    e0 = n_errors;
    for (int i = 0; i < q_data.size() && i <= M && n_errors == e0; i++) begin
      if (i == 0) want = hdr;
      else        want = exp_mem[i-1];
      check($sformatf("beat%0d_data", i), 32'(q_data[i]), 32'(want));
      check($sformatf("beat%0d_first", i), 32'(q_first[i]), 32'(i == 0));
      check($sformatf("beat%0d_last", i), 32'(q_last[i]), 32'(i == M));
    end
  endtask

  task automatic run_frame(input logic [OUT_W-1:0] hdr, input bit b2b);
    int k;
    int cyc;
    clear_q();
    pulse_done();
    tick();
    k = 1;
    check("busy_start", 32'(busy), 32'(1));
    check("rd_addr_start", 32'(rd_addr), 32'(0));
    while (!m_valid && k < M + 20) begin
      tick();
      k++;
      if (k == M) check("rd_addr_last", 32'(rd_addr), 32'(M - 1));
    end
    check("first_valid_latency", 32'(k), 32'(M + 2));
    cyc = 0;
    while (q_data.size() < M + 1 && cyc < 20000) begin
      tick();
      cyc++;
    end
    if (b2b) check("back_to_back", 32'(cyc), 32'(M));
    tick();
    check("busy_end", 32'(busy), 32'(0));
    check("valid_end", 32'(m_valid), 32'(0));
    check_frame(hdr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    fill_ramp();
    repeat (3) tick();
    check("rst_rd_addr", 32'(rd_addr), 32'(0));
    check("rst_m_valid", 32'(m_valid), 32'(0));
    check("rst_m_first", 32'(m_first), 32'(0));
    check("rst_m_last", 32'(m_last), 32'(0));
    check("rst_m_data", 32'(m_data), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_overrun", 32'(overrun), 32'(0));
    check("rst_sat_seen", 32'(sat_seen), 32'(0));
    check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    // Basic ramp frame
    run_frame(16'h0000, 1'b1);
    check("basic_frame_cnt", 32'(frame_cnt), 32'(1));
    check("basic_sat", 32'(sat_seen), 32'(0));

    // Scaling and saturation corners
    enc_mem[0] = 24'h012345; exp_mem[0] = 16'd1165;
    enc_mem[1] = 24'h7FFFFF; exp_mem[1] = 16'h7FFF;
    enc_mem[2] = 24'hFFFFFF; exp_mem[2] = 16'hFFFF;
    enc_mem[3] = 24'hFFFF9C; exp_mem[3] = 16'hFFFE;
    enc_mem[4] = 24'h800000; exp_mem[4] = 16'h8000;
    run_frame(16'h0001, 1'b1);
    check("sat_seen_set", 32'(sat_seen), 32'(1));
    check("sat_frame_cnt", 32'(frame_cnt), 32'(2));

    fill_ramp();
    run_frame(16'h0002, 1'b1);
    check("sat_seen_clear", 32'(sat_seen), 32'(0));

    // Backpressure with negative values: (-192k-1)>>>6 = -3k-1
    for (int k = 0; k < M; k++) begin
      enc_mem[k] = IN_W'(-(k * 192) - 1);
      exp_mem[k] = OUT_W'(-(k * 3) - 1);
    end
    rand_rdy = 1'b1;
    run_frame(16'h0003, 1'b0);
    rand_rdy = 1'b0;
    check("bp_frame_cnt", 32'(frame_cnt), 32'(4));
    check("bp_overrun", 32'(overrun), 32'(0));

    // Overrun: pulse during LOAD and one coincident with the final transfer
    fill_ramp();
    clear_q();
    pulse_done();
    repeat (10) tick();
    pulse_done();
    tick();
    check("ovr_set", 32'(overrun), 32'(1));
    check("ovr_busy", 32'(busy), 32'(1));
    c = 0;
    while (!(m_valid && m_last && m_ready) && c < 5000) begin
      tick();
      c++;
    end
    encoder_done = 1'b1;
    @(posedge clk);
    #1 encoder_done = 1'b0;
    tick();
    check("ovr_idle", 32'(busy), 32'(0));
    check("ovr_frame_cnt", 32'(frame_cnt), 32'(5));
    repeat (4) tick();
    check("ovr_no_restart", 32'(busy), 32'(0));
    check("ovr_no_valid", 32'(m_valid), 32'(0));
    check("ovr_sticky", 32'(overrun), 32'(1));
    check_frame(16'h0004);
    run_frame(16'h0005, 1'b1);
    check("post_ovr_frame_cnt", 32'(frame_cnt), 32'(6));

    // Reset in the middle of SEND
    clear_q();
    pulse_done();
    c = 0;
    while (q_data.size() < 100 && c < 5000) begin
      tick();
      c++;
    end
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 32'(m_valid), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'(0));
    check("mid_rst_overrun", 32'(overrun), 32'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    run_frame(16'h0000, 1'b1);
    check("after_rst_frame_cnt", 32'(frame_cnt), 32'(1));

    // Frame counter wrap
    tick();
    force dut.r_frame_cnt = 16'hFFFF;
    tick();
    release dut.r_frame_cnt;
    tick();
    check("wrap_preload", 32'(frame_cnt), 32'(16'hFFFF));
    run_frame(16'hFFFF, 1'b1);
    check("wrap_frame_cnt", 32'(frame_cnt), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
